// File: rtl/hms_counter.sv
// hms_counter
// Hours:minutes:seconds time core with configurable field moduli, an enable
// prescaler, up/down counting, synchronous clear/load, lap capture and
// rollover/expiry flags.
//
// Parameters
//   DIV      enabled clk cycles per count step (>=1)
//   SEC_MOD  seconds modulus (>=2)
//   MIN_MOD  minutes modulus (>=2)
//   HR_MOD   hours modulus (>=2)
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   enable                       advance the prescaler this cycle
//   mode_down                    0 = count up, 1 = count down
//   clear / load                 synchronous zero / load (clear wins)
//   load_sec/min/hr              load values, clamped to modulus-1
//   lap_capture                  snapshot the pre-edge count
//   seconds/minutes/hours        current count
//   lap_sec/min/hr, lap_valid    last captured count, capture-seen flag
//   sec_carry                    combinational seconds carry/borrow
//   wrap                         one-cycle pulse after up-mode full rollover
//   expired                      sticky, countdown reached zero
module hms_counter #(
    parameter int DIV     = 1,
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60,
    parameter int HR_MOD  = 24,
    localparam int SEC_W  = $clog2(SEC_MOD),
    localparam int MIN_W  = $clog2(MIN_MOD),
    localparam int HR_W   = $clog2(HR_MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode_down,
    input  logic             clear,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic [MIN_W-1:0] load_min,
    input  logic [HR_W-1:0]  load_hr,
    input  logic             lap_capture,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic [SEC_W-1:0] lap_sec,
    output logic [MIN_W-1:0] lap_min,
    output logic [HR_W-1:0]  lap_hr,
    output logic             lap_valid,
    output logic             sec_carry,
    output logic             wrap,
    output logic             expired
);

    // DIV==1 still gets a 1-bit counter; it simply never leaves 0.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0] MIN_MAX  = MIN_W'(MIN_MOD - 1);
    localparam logic [HR_W-1:0]  HR_MAX   = HR_W'(HR_MOD - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             step;

    logic sec_max, min_max, hr_max, all_max;
    logic sec_zero, min_zero, hr_zero, all_zero;
    logic last_sec;

    logic [SEC_W-1:0] sec_nxt, sec_ld;
    logic [MIN_W-1:0] min_nxt, min_ld;
    logic [HR_W-1:0]  hr_nxt,  hr_ld;

    assign step = enable && (div_cnt == DIV_LAST);

    assign sec_max  = (seconds == SEC_MAX);
    assign min_max  = (minutes == MIN_MAX);
    assign hr_max   = (hours == HR_MAX);
    assign all_max  = sec_max && min_max && hr_max;
    assign sec_zero = (seconds == '0);
    assign min_zero = (minutes == '0);
    assign hr_zero  = (hours == '0);
    assign all_zero = sec_zero && min_zero && hr_zero;
    // 00:00:01 is the only count whose down step lands on zero.
    assign last_sec = (seconds == SEC_W'(1)) && min_zero && hr_zero;

    // Out-of-range load fields saturate rather than wrap.
    assign sec_ld = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
    assign min_ld = (load_min > MIN_MAX) ? MIN_MAX : load_min;
    assign hr_ld  = (load_hr  > HR_MAX)  ? HR_MAX  : load_hr;

    // Down mode at zero carries nothing: the count parks there.
    assign sec_carry = step && (mode_down ? (sec_zero && !(min_zero && hr_zero))
                                          : sec_max);

    // Count value after one step in the current direction.
    always_comb begin
        sec_nxt = seconds;
        min_nxt = minutes;
        hr_nxt  = hours;
        if (!mode_down) begin
            if (sec_max) begin
                sec_nxt = '0;
                if (min_max) begin
                    min_nxt = '0;
                    hr_nxt  = hr_max ? '0 : hours + HR_W'(1);
                end else begin
                    min_nxt = minutes + MIN_W'(1);
                end
            end else begin
                sec_nxt = seconds + SEC_W'(1);
            end
        end else if (!all_zero) begin
            if (sec_zero) begin
                sec_nxt = SEC_MAX;
                if (min_zero) begin
                    min_nxt = MIN_MAX;
                    hr_nxt  = hours - HR_W'(1);
                end else begin
                    min_nxt = minutes - MIN_W'(1);
                end
            end else begin
                sec_nxt = seconds - SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            seconds   <= '0;
            minutes   <= '0;
            hours     <= '0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_hr    <= '0;
            lap_valid <= 1'b0;
            wrap      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            wrap <= 1'b0;

            // Lap always sees the pre-edge count, whatever else happens.
            if (lap_capture) begin
                lap_sec   <= seconds;
                lap_min   <= minutes;
                lap_hr    <= hours;
                lap_valid <= 1'b1;
            end

            if (clear) begin
                div_cnt <= '0;
                seconds <= '0;
                minutes <= '0;
                hours   <= '0;
                expired <= 1'b0;
            end else if (load) begin
                div_cnt <= '0;
                seconds <= sec_ld;
                minutes <= min_ld;
                hours   <= hr_ld;
                expired <= 1'b0;
            end else begin
                if (enable)
                    div_cnt <= step ? '0 : div_cnt + DIV_W'(1);
                if (step) begin
                    seconds <= sec_nxt;
                    minutes <= min_nxt;
                    hours   <= hr_nxt;
                    if (!mode_down && all_max)
                        wrap <= 1'b1;
                    if (mode_down && last_sec)
                        expired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/hms_counter.md
# hms_counter

Parametrised hours:minutes:seconds time core for the stopwatch/timer datapath. Generalises the single-field seconds counter with configurable moduli for all three fields, a built-in enable prescaler, up/down (stopwatch/countdown) mode, synchronous load and clear, lap capture, and rollover/expiry flags. It sits between the tick/enable source and the display formatter.

## Interface
- DIV, 1: enabled clk cycles per count step; must be ≥1 (1 = step on every enabled cycle)
- SEC_MOD, 60: seconds modulus; must be ≥2; SEC_W = $clog2(SEC_MOD)
- MIN_MOD, 60: minutes modulus; must be ≥2; MIN_W = $clog2(MIN_MOD)
- HR_MOD, 24: hours modulus; must be ≥2; HR_W = $clog2(HR_MOD)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  advance the prescaler this cycle
- mode_down  in  1  0 = count up (stopwatch), 1 = count down (timer)
- clear  in  1  synchronous zero of count, prescaler, expired
- load  in  1  synchronous load of count from load_* inputs
- load_sec / load_min / load_hr  in  SEC_W / MIN_W / HR_W  load values
- lap_capture  in  1  snapshot the current count into the lap registers
- seconds / minutes / hours  out  SEC_W / MIN_W / HR_W  current count
- lap_sec / lap_min / lap_hr  out  SEC_W / MIN_W / HR_W  last captured count
- lap_valid  out  1  high once any lap has been captured
- sec_carry  out  1  combinational: seconds carries/borrows this cycle
- wrap  out  1  registered one-cycle pulse on up-mode full rollover
- expired  out  1  registered sticky flag, countdown reached zero

## Operation
- Reset: every register and output is 0, including the prescaler, count, lap regs, lap_valid, wrap, and expired.
- Prescaler: div_cnt counts enabled cycles 0..DIV-1. The internal step = enable && div_cnt==DIV-1. On step, div_cnt returns to 0. When enable is low, div_cnt holds.
- Priority order: clear > load > step.
  - clear: count=0, div_cnt=0, expired=0.
  - load: count=load_*, div_cnt=0, expired=0.
- Load clamping: any load field ≥ its modulus is clamped to modulus-1. Example: load_sec=63 with SEC_MOD=60 gives 59.
- Up step: seconds+1. At SEC_MOD-1, seconds wraps to 0 and minutes+1. The same rule applies minutes→hours. At 23:59:59 (all fields at max) the count goes to 00:00:00 and wrap pulses on the following cycle.
- Down step: seconds-1. At 0, seconds goes to SEC_MOD-1 and minutes borrows (likewise minutes→hours).
  - A step from a count with only seconds==1 and all else 0 (00:00:01) gives 00:00:00 and sets expired.
  - Steps at 00:00:00 hold the count: no borrow into the hours field, no wrap.
  - Down mode never asserts wrap.
- expired stays high until clear, load, or reset. It is never set in up mode.
- sec_carry is combinational:
  - up mode: step && seconds==SEC_MOD-1;
  - down mode: step && seconds==0 && (minutes!=0 || hours!=0).
- mode_down may change at any cycle. It only affects the next step; div_cnt is not disturbed.
- Lap capture:
  - On lap_capture, lap_* take the pre-edge count and lap_valid=1.
  - If the capture coincides with step, clear, or load, the captured value is the count before that update.
  - Lap registers and lap_valid are only reset by rst_n; clear does not affect them.

## Timing
- All state updates on posedge clk.
- Count latency: count changes on the edge where step is true. With enable held high from reset release, the first increment appears after DIV edges.
- clear/load take effect on the same edge they are sampled. The next step is DIV enabled cycles after that.
- wrap and expired are visible one cycle after the terminal step edge, i.e. in the cycle the new count (00:00:00) is visible.
- lap_* are visible the cycle after lap_capture.
- Reset mid-operation: on the next edge with rst_n low, all state returns to 0 regardless of other inputs.

## Test plan
- DIV=4, up mode, enable high from reset → seconds=1 after 4 edges and 2 after 8; enable dropped for 3 cycles → div_cnt and count hold.
- Default moduli, DIV=1, load 23:59:58, up mode, 2 steps:
  - step 1 → 23:59:59 with sec_carry high in that cycle;
  - step 2 → 00:00:00 with wrap=1 for exactly one cycle.
- Down mode, load 00:01:00, DIV=1, step → 00:00:59 with sec_carry=1 on that step; continue to 00:00:00 → expired=1; 5 more steps → count stays 00:00:00, expired stays 1, wrap stays 0.
- load_sec=62, load_min=70, load_hr=30 → 23:59:59 (clamped); clear and load in the same cycle → 00:00:00.
- lap_capture with the count at 00:00:09 in the same cycle as a step → count 00:00:10, lap 00:00:09, lap_valid=1; subsequent clear → lap unchanged.
- rst_n low mid-count at 00:12:34 with expired=1, then released → all outputs 0, first step after DIV enabled cycles.
